// File: rtl/cartoon_compose.sv
// cartoon_compose: posterizes the blurred centre pixel and overlays black,
// horizontally thickened outlines where the edge magnitude beats an
// adaptive threshold. Two-stage pipeline; the threshold retunes once per
// frame from the number of edge hits seen in that frame.
module cartoon_compose #(
  parameter int         POST_BITS   = 2,
  parameter int         DILATE      = 2,
  parameter logic [7:0] THRESH_INIT = 8'd40,
  parameter logic [7:0] THRESH_MIN  = 8'd16,
  parameter logic [7:0] THRESH_MAX  = 8'd200,
  parameter logic [7:0] THRESH_STEP = 8'd4,
  parameter logic [19:0] HI_COUNT   = 20'd40000,
  parameter logic [19:0] LO_COUNT   = 20'd10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        auto_en,
  input  logic        pix_valid,
  input  logic [12:0] col,
  input  logic        frame_end,
  input  logic [7:0]  edge_in,
  input  logic [23:0] blur_in,
  input  logic [23:0] pass_in,
  output logic [23:0] out_rgb,
  output logic        out_valid,
  output logic [7:0]  threshold,
  output logic [19:0] edge_count
);

  // Number of copies of the kept bits needed to refill a byte.
  localparam int         REP = 8 / POST_BITS;
  localparam logic [2:0] DIL = 3'(DILATE);

  logic [2:0]  run;
  logic [19:0] acc;
  logic        hit;
  logic        carry;
  logic        outline;
  logic [23:0] post;
  logic [19:0] acc_final;
  logic [8:0]  thr_up;
  logic [8:0]  thr_floor;

  logic        s1_valid;
  logic        s1_outline;
  logic [23:0] s1_post;
  logic [23:0] s1_pass;

  // An edge hit is a strict unsigned compare against the live threshold.
  assign hit = pix_valid && (edge_in > threshold);

  // A pending outline run only continues within the same line.
  assign carry   = (col != 13'd0) && (run != 3'd0);
  assign outline = hit || carry;

  // Per-channel posterize: keep the top bits and replicate them downward,
  // so full-scale inputs stay full-scale and black stays black.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_post
      assign post[gi*8 +: 8] = {REP{blur_in[gi*8 + 8 - POST_BITS +: POST_BITS]}};
    end
  endgenerate

  // Accumulator value including this cycle's hit, saturating at all ones.
  assign acc_final = (hit && (acc != 20'hFFFFF)) ? acc + 20'd1 : acc;

  // 9-bit clamp arithmetic so neither direction can wrap in 8 bits.
  assign thr_up    = {1'b0, threshold} + {1'b0, THRESH_STEP};
  assign thr_floor = {1'b0, THRESH_MIN} + {1'b0, THRESH_STEP};

  // Stage 1: capture outline decision, posterized colour and bypass pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_outline <= 1'b0;
      s1_post    <= 24'd0;
      s1_pass    <= 24'd0;
    end else begin
      s1_valid   <= pix_valid;
      s1_outline <= outline;
      s1_post    <= post;
      s1_pass    <= pass_in;
    end
  end

  // Dilation run: reload on a hit, count down otherwise, only on valid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 3'd0;
    end else if (pix_valid) begin
      if (hit)        run <= DIL;
      else if (carry) run <= run - 3'd1;
      else            run <= 3'd0;
    end
  end

  // Stage 2: choose between outline black, posterized colour and bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rgb   <= 24'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (en) out_rgb <= s1_outline ? 24'h000000 : s1_post;
      else    out_rgb <= s1_pass;
    end
  end

  // Per-frame hit accounting and adaptive threshold update at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 20'd0;
      edge_count <= 20'd0;
      threshold  <= THRESH_INIT;
    end else if (frame_end) begin
      acc        <= 20'd0;
      edge_count <= acc_final;
      if (auto_en) begin
        if (acc_final > HI_COUNT) begin
          threshold <= (thr_up > {1'b0, THRESH_MAX}) ? THRESH_MAX : thr_up[7:0];
        end else if (acc_final < LO_COUNT) begin
          threshold <= ({1'b0, threshold} < thr_floor) ? THRESH_MIN
                                                       : threshold - THRESH_STEP;
        end
      end
    end else begin
      acc <= acc_final;
    end
  end

endmodule

// File: tb/tb_cartoon_compose.sv
// Scoreboard bench for cartoon_compose: the stimulus process predicts each
// output pixel from a behavioural model and queues it; a negedge monitor
// pops and compares whenever out_valid is seen.
module tb_cartoon_compose;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        auto_en;
  logic        pix_valid;
  logic [12:0] col;
  logic        frame_end;
  logic [7:0]  edge_in;
  logic [23:0] blur_in;
  logic [23:0] pass_in;
  logic [23:0] out_rgb;
  logic        out_valid;
  logic [7:0]  threshold;
  logic [19:0] edge_count;

  cartoon_compose dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .auto_en    (auto_en),
    .pix_valid  (pix_valid),
    .col        (col),
    .frame_end  (frame_end),
    .edge_in    (edge_in),
    .blur_in    (blur_in),
    .pass_in    (pass_in),
    .out_rgb    (out_rgb),
    .out_valid  (out_valid),
    .threshold  (threshold),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];

  // Reference model state
  int m_thr  = 40;
  int m_acc  = 0;
  int m_cnt  = 0;
  int m_dist = 99;   // valid pixels since last hit on this line (99 = none)

  // Posterize by rescaling the 2-bit level onto 0..255.
  function automatic logic [7:0] post_ch(input logic [7:0] c);
    int lvl;
    lvl = int'(c) / 64;
    return 8'(lvl * 255 / 3);
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present one cycle of input, predict its result, then advance the clock.
  task automatic pix(input logic v, input int c, input int e,
                     input logic [23:0] b, input logic [23:0] p, input logic fe);
    logic hit_m;
    logic outl_m;
    int   fin;
    pix_valid = v;
    col       = 13'(c);
    edge_in   = 8'(e);
    blur_in   = b;
    pass_in   = p;
    frame_end = fe;
    hit_m  = v && (e > m_thr);
    outl_m = 1'b0;
    if (v) begin
      outl_m = hit_m || ((c != 0) && (m_dist <= 2));
      if (en) exp_q.push_back(outl_m ? 24'h0 : {post_ch(b[23:16]), post_ch(b[15:8]), post_ch(b[7:0])});
      else    exp_q.push_back(p);
      if (hit_m)          m_dist = 1;
      else if (c == 0)    m_dist = 99;
      else if (m_dist < 99) m_dist++;
    end
    fin = m_acc + (hit_m ? 1 : 0);
    if (fin > 20'hFFFFF) fin = 20'hFFFFF;
    if (fe) begin
      m_cnt = fin;
      m_acc = 0;
      if (auto_en) begin
        if (fin > 40000)      m_thr = (m_thr + 4 > 200) ? 200 : m_thr + 4;
        else if (fin < 10000) m_thr = (m_thr - 4 < 16) ? 16 : m_thr - 4;
      end
    end else begin
      m_acc = fin;
    end
    @(posedge clk);
    #1;
    if (fe) begin
      check("threshold", int'(threshold), m_thr);
      check("edge_count", int'(edge_count), m_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 0, 0, 24'h0, 24'h0, 1'b0);
  endtask

  // Monitor: every valid output must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_rgb", int'(out_rgb), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0; en = 1'b1; auto_en = 1'b0; pix_valid = 1'b0; col = '0;
    frame_end = 1'b0; edge_in = '0; blur_in = '0; pass_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_threshold", int'(threshold), 40);
    check("reset_edge_count", int'(edge_count), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_rgb", int'(out_rgb), 0);
    rst_n = 1'b1;
    idle(2);

    // Latency and posterize of a fixed colour
    pix(1'b1, 0, 0, 24'hC54580, 24'h0, 1'b0);
    check("latency_early", int'(out_valid), 0);
    pix(1'b1, 1, 0, 24'hC54580, 24'h0, 1'b0);
    check("latency_at_2", int'(out_valid), 1);
    pix(1'b1, 2, 0, 24'hC54580, 24'h0, 1'b0);
    check("latency_rgb", int'(out_rgb), 24'hFF55AA);
    idle(3);

    // Dilation of a single hit, and strict compare at edge == threshold
    pix(1'b1, 10, 41, 24'h80C040, 24'h0, 1'b0);
    for (int i = 11; i <= 14; i++) pix(1'b1, i, 0, 24'h80C040, 24'h0, 1'b0);
    pix(1'b1, 15, 40, 24'h80C040, 24'h0, 1'b0);
    pix(1'b1, 16, 0, 24'h80C040, 24'h0, 1'b0);

    // No carry across a line boundary
    pix(1'b1, 19, 100, 24'hFFFFFF, 24'h0, 1'b0);
    pix(1'b1, 0, 0, 24'hFFFFFF, 24'h0, 1'b0);
    pix(1'b1, 1, 0, 24'hFFFFFF, 24'h0, 1'b0);
    idle(3);

    // Bypass
    en = 1'b0;
    pix(1'b1, 2, 255, 24'hABCDEF, 24'h123456, 1'b0);
    pix(1'b1, 3, 0, 24'hABCDEF, 24'h654321, 1'b0);
    idle(3);
    en = 1'b1;

    // Close the current frame without adaptation, then 40001 hits with auto
    pix(1'b0, 0, 0, 24'h0, 24'h0, 1'b1);
    auto_en = 1'b1;
    for (int i = 0; i < 40000; i++)
      pix(1'b1, i % 100, 255, 24'($urandom), 24'h0, 1'b0);
    pix(1'b1, 0, 255, 24'h00FF00, 24'h0, 1'b1);
    check("edge_count_40001", int'(edge_count), 40001);
    check("threshold_up", int'(threshold), 44);
    pix(1'b0, 0, 0, 24'h0, 24'h0, 1'b1);   // accumulator must have been cleared
    check("acc_cleared", int'(edge_count), 0);

    // Small frames walk the threshold down onto its floor
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 5; i++) pix(1'b1, i, 255, 24'h808080, 24'h0, 1'b0);
      pix(1'b0, 0, 0, 24'h0, 24'h0, 1'b1);
    end
    check("threshold_floor", int'(threshold), 16);
    idle(3);

    // Randomized traffic
    c = 0;
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic fe;
      v  = ($urandom_range(0, 3) != 0);
      fe = ($urandom_range(0, 199) == 0);
      if (fe) auto_en = 1'($urandom);
      pix(v, c, $urandom_range(0, 80), 24'($urandom), 24'($urandom), fe);
      if (v) c = (c + 1) % 64;
    end
    idle(3);

    // Reset mid-frame loses accumulated hits
    auto_en = 1'b1;
    for (int i = 0; i < 3; i++) pix(1'b1, i, 255, 24'h0, 24'h0, 1'b0);
    pix(1'b0, 0, 0, 24'h0, 24'h0, 1'b1);
    for (int i = 0; i < 4; i++) pix(1'b1, i, 255, 24'h0, 24'h0, 1'b0);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_threshold", int'(threshold), 40);
    check("midreset_edge_count", int'(edge_count), 0);
    m_thr = 40; m_acc = 0; m_cnt = 0; m_dist = 99;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pix(1'b1, 0, 255, 24'h0, 24'h0, 1'b0);
    pix(1'b1, 1, 255, 24'h0, 24'h0, 1'b0);
    pix(1'b0, 0, 0, 24'h0, 24'h0, 1'b1);
    check("post_reset_count", int'(edge_count), 2);

    idle(4);
    check("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
